// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the fetch/data requesters, the arbiter and the memory port.
// The master view belongs to the arbiter; the slave view to whatever drives requests and memory.
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
) ();
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_gnt;
   logic          i_rvalid;
   logic [DW-1:0] i_rdata;
   logic          i_err;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [3:0]    d_wstrb;
   logic          d_gnt;
   logic          d_rvalid;
   logic [DW-1:0] d_rdata;
   logic          d_err;
   logic          m_req;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [3:0]    m_wstrb;
   logic          m_ready;
   logic          m_rvalid;
   logic [DW-1:0] m_rdata;

   modport master (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb,
      input  m_ready, m_rvalid, m_rdata,
      output i_gnt, i_rvalid, i_rdata, i_err,
      output d_gnt, d_rvalid, d_rdata, d_err,
      output m_req, m_we, m_addr, m_wdata, m_wstrb
   );

   modport slave (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb,
      output m_ready, m_rvalid, m_rdata,
      input  i_gnt, i_rvalid, i_rdata, i_err,
      input  d_gnt, d_rvalid, d_rdata, d_err,
      input  m_req, m_we, m_addr, m_wdata, m_wstrb
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store; one transaction in flight, data first,
// with a streak limit so fetch is never starved, and an abort-with-error on memory timeout.
module mem_port_arbiter #(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int MAX_D_STREAK = 4,
   parameter int TIMEOUT      = 16
) (
   input logic                clk,
   input logic                rst_n,
   mem_port_arbiter_if.master bus
);
   localparam int SW = $clog2(MAX_D_STREAK + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0] STREAK_MAX   = SW'(MAX_D_STREAK);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t        state;
   logic          owner_d;
   logic [SW-1:0] streak;
   logic [TW-1:0] tcount;
   logic          win_d;
   logic          win_i;
   logic          in_wait;

   always_comb begin
      win_d = bus.d_req && !(bus.i_req && (streak == STREAK_MAX));
      win_i = bus.i_req && !win_d;
   end

   // Responses are only honoured while waiting; late ones after a timeout fall on the floor.
   assign in_wait      = (state == WAIT);
   assign bus.i_rvalid = in_wait && !owner_d && bus.m_rvalid;
   assign bus.d_rvalid = in_wait &&  owner_d && bus.m_rvalid;
   assign bus.i_rdata  = (in_wait && !owner_d) ? bus.m_rdata : {DW{1'b0}};
   assign bus.d_rdata  = (in_wait &&  owner_d) ? bus.m_rdata : {DW{1'b0}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         owner_d     <= 1'b0;
         streak      <= '0;
         tcount      <= '0;
         bus.i_gnt   <= 1'b0;
         bus.d_gnt   <= 1'b0;
         bus.i_err   <= 1'b0;
         bus.d_err   <= 1'b0;
         bus.m_req   <= 1'b0;
         bus.m_we    <= 1'b0;
         bus.m_addr  <= {AW{1'b0}};
         bus.m_wdata <= {DW{1'b0}};
         bus.m_wstrb <= 4'h0;
      end else begin
         bus.i_gnt <= 1'b0;
         bus.d_gnt <= 1'b0;
         bus.i_err <= 1'b0;
         bus.d_err <= 1'b0;
         case (state)
            IDLE: begin
               if (win_d) begin
                  owner_d     <= 1'b1;
                  bus.d_gnt   <= 1'b1;
                  bus.m_req   <= 1'b1;
                  bus.m_we    <= bus.d_we;
                  bus.m_addr  <= bus.d_addr;
                  bus.m_wdata <= bus.d_wdata;
                  bus.m_wstrb <= bus.d_wstrb;
                  // Only a grant that made fetch wait counts toward the streak.
                  if (bus.i_req)
                     streak <= (streak == STREAK_MAX) ? streak : streak + 1'b1;
                  else
                     streak <= '0;
                  state <= ISSUE;
               end else if (win_i) begin
                  owner_d     <= 1'b0;
                  bus.i_gnt   <= 1'b1;
                  bus.m_req   <= 1'b1;
                  bus.m_we    <= 1'b0;
                  bus.m_addr  <= bus.i_addr;
                  bus.m_wdata <= {DW{1'b0}};
                  bus.m_wstrb <= 4'h0;
                  streak      <= '0;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (bus.m_ready) begin
                  bus.m_req <= 1'b0;
                  tcount    <= '0;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (bus.m_rvalid) begin
                  state <= IDLE;
               end else if (tcount == TIMEOUT_LAST) begin
                  if (owner_d) bus.d_err <= 1'b1;
                  else         bus.i_err <= 1'b1;
                  state <= IDLE;
               end else begin
                  tcount <= tcount + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios followed by randomized traffic, all scored against a transaction-level model.
module tb_mem_port_arbiter;
   localparam int MAXS = 4;
   localparam int TOUT = 16;
   localparam int PH_IDLE = 0, PH_ISSUE = 1, PH_WAIT = 2;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

   mem_port_arbiter #(.AW(32), .DW(32), .MAX_D_STREAK(MAXS), .TIMEOUT(TOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: phase of the single outstanding transaction and the values the port should carry.
   int          ph = PH_IDLE;
   bit          own_d = 1'b0;
   int          streak = 0;
   int          waited = 0;
   bit          e_i_gnt, e_d_gnt, e_i_err, e_d_err, e_m_req, e_m_we;
   logic [31:0] e_m_addr, e_m_wdata;
   logic [3:0]  e_m_wstrb;

   logic        obs_i_rv, obs_d_rv;
   logic [31:0] obs_i_rd, obs_d_rd;
   int          gnt_cyc = 0;
   int          err_cyc = 0;
   string       glog = "";
   string       exp_order = "DDDDIDDDDI";
   bit          pend_i = 1'b0;
   bit          pend_d = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      ph = PH_IDLE; own_d = 1'b0; streak = 0; waited = 0;
      e_i_gnt = 0; e_d_gnt = 0; e_i_err = 0; e_d_err = 0;
      e_m_req = 0; e_m_we = 0; e_m_addr = '0; e_m_wdata = '0; e_m_wstrb = '0;
   endtask

   task automatic model_edge();
      bit win_d;
      e_i_gnt = 0; e_d_gnt = 0; e_i_err = 0; e_d_err = 0;
      if (ph == PH_IDLE) begin
         if (bus.d_req && bus.i_req) win_d = (streak < MAXS);
         else                        win_d = bus.d_req;
         if (win_d || bus.i_req) begin
            own_d   = win_d;
            ph      = PH_ISSUE;
            e_m_req = 1;
            if (win_d) begin
               e_d_gnt = 1; e_m_we = bus.d_we; e_m_addr = bus.d_addr;
               e_m_wdata = bus.d_wdata; e_m_wstrb = bus.d_wstrb;
               streak = bus.i_req ? ((streak + 1 > MAXS) ? MAXS : streak + 1) : 0;
            end else begin
               e_i_gnt = 1; e_m_we = 0; e_m_addr = bus.i_addr;
               e_m_wdata = '0; e_m_wstrb = '0;
               streak = 0;
            end
         end
      end else if (ph == PH_ISSUE) begin
         if (bus.m_ready) begin
            ph = PH_WAIT; e_m_req = 0; waited = 0;
         end
      end else begin
         if (bus.m_rvalid) ph = PH_IDLE;
         else begin
            waited++;
            if (waited == TOUT) begin
               ph = PH_IDLE;
               if (own_d) e_d_err = 1; else e_i_err = 1;
            end
         end
      end
   endtask

   // Called with inputs freshly driven in the low phase; returns at the next falling edge.
   task automatic step();
      bit exp_rv;
      #1;
      exp_rv = (ph == PH_WAIT) && bus.m_rvalid;
      obs_i_rv = bus.i_rvalid; obs_d_rv = bus.d_rvalid;
      obs_i_rd = bus.i_rdata;  obs_d_rd = bus.d_rdata;
      check("i_rvalid", obs_i_rv, exp_rv && !own_d);
      check("d_rvalid", obs_d_rv, exp_rv && own_d);
      if (own_d) check("i_rdata_idle", obs_i_rd, 0);
      else       check("d_rdata_idle", obs_d_rd, 0);
      if (exp_rv) check(own_d ? "d_rdata" : "i_rdata", own_d ? obs_d_rd : obs_i_rd, bus.m_rdata);
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      check("i_gnt", bus.i_gnt, e_i_gnt);
      check("d_gnt", bus.d_gnt, e_d_gnt);
      check("i_err", bus.i_err, e_i_err);
      check("d_err", bus.d_err, e_d_err);
      check("m_req", bus.m_req, e_m_req);
      check("m_we", bus.m_we, e_m_we);
      check("m_addr", bus.m_addr, e_m_addr);
      check("m_wdata", bus.m_wdata, e_m_wdata);
      check("m_wstrb", bus.m_wstrb, e_m_wstrb);
      if (bus.d_gnt) begin glog = {glog, "D"}; gnt_cyc = cyc; end
      if (bus.i_gnt) begin glog = {glog, "I"}; gnt_cyc = cyc; end
      if (bus.d_err || bus.i_err) err_cyc = cyc;
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_outs"}, {bus.i_gnt, bus.d_gnt, bus.i_err, bus.d_err, bus.i_rvalid,
                             bus.d_rvalid, bus.m_req, bus.m_we, bus.m_wstrb}, 0);
      check({tag, "_addr"}, bus.m_addr, 0);
      check({tag, "_data"}, {bus.m_wdata, bus.i_rdata}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      bus.i_req = 0; bus.i_addr = '0;
      bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
      bus.m_ready = 0; bus.m_rvalid = 0; bus.m_rdata = '0;
      model_reset();
      @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;

      // Single fetch, memory ready at once, response one cycle later.
      bus.i_req = 1; bus.i_addr = 32'h100; bus.m_ready = 1;
      step();
      check("fetch_gnt", bus.i_gnt, 1);
      check("fetch_addr", bus.m_addr, 32'h100);
      bus.i_req = 0;
      step();
      bus.m_rvalid = 1; bus.m_rdata = 32'h13; bus.m_ready = 0;
      step();
      check("fetch_rvalid", obs_i_rv, 1);
      check("fetch_rdata", obs_i_rd, 32'h13);
      check("fetch_no_d", obs_d_rv, 0);
      bus.m_rvalid = 0;
      step();

      // Store held off by memory backpressure for three cycles.
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h2000; bus.d_wdata = 32'hDEADBEEF;
      bus.d_wstrb = 4'hF; bus.m_ready = 0;
      step();
      check("store_gnt", bus.d_gnt, 1);
      bus.d_req = 0; bus.d_wdata = 32'h0;
      step(); step(); step();
      check("store_mreq4", bus.m_req, 1);
      check("store_wdata", bus.m_wdata, 32'hDEADBEEF);
      bus.m_ready = 1;
      step();
      bus.m_ready = 0; bus.m_rvalid = 1;
      step();
      check("store_ack", obs_d_rv, 1);
      bus.m_rvalid = 0;
      step();

      // Both requesters saturated: fetch forced after every fourth data grant.
      bus.i_req = 1; bus.i_addr = 32'h40; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h80;
      bus.m_ready = 1; bus.m_rvalid = 1;
      glog = "";
      for (int k = 0; k < 40 && glog.len() < 10; k++) step();
      check("fair_count", glog.len(), 10);
      for (int k = 0; k < 10; k++)
         check("fair_order", (k < glog.len()) ? glog[k] : 8'h0, exp_order[k]);
      bus.i_req = 0; bus.d_req = 0; bus.m_rvalid = 0;
      for (int k = 0; k < 25; k++) step();

      // Load that never gets a response, then a stray late response.
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h3000; bus.m_ready = 1;
      step();
      bus.d_req = 0;
      for (int k = 0; k < 20; k++) step();
      check("timeout_cycles", err_cyc - gnt_cyc, 17);
      bus.m_rvalid = 1;
      step();
      check("late_rvalid", obs_d_rv, 0);
      step();
      bus.m_rvalid = 0;

      // Asynchronous reset while waiting for a response.
      bus.d_req = 1; bus.m_ready = 1;
      step();
      bus.d_req = 0;
      step();
      bus.m_rvalid = 1; bus.m_rdata = 32'hCAFE;
      #1;
      check("pre_reset_rvalid", bus.d_rvalid, 1);
      #1 rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      model_reset();
      bus.m_rvalid = 0; bus.i_req = 1; bus.i_addr = 32'h400;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("post_reset_gnt", bus.i_gnt, 1);
      check("post_reset_addr", bus.m_addr, 32'h400);
      bus.i_req = 0;

      // Randomized traffic: requests hold until granted, memory timing random.
      for (int k = 0; k < 3000; k++) begin
         if (e_i_gnt) pend_i = 0;
         if (e_d_gnt) pend_d = 0;
         if (!pend_i && $urandom_range(0, 2) == 0) begin
            pend_i = 1; bus.i_addr = $urandom;
         end
         if (!pend_d && $urandom_range(0, 2) == 0) begin
            pend_d = 1; bus.d_we = $urandom_range(0, 1); bus.d_addr = $urandom;
            bus.d_wdata = $urandom; bus.d_wstrb = 4'($urandom_range(0, 15));
         end
         bus.i_req    = pend_i;
         bus.d_req    = pend_d;
         bus.m_ready  = $urandom_range(0, 1);
         bus.m_rvalid = ($urandom_range(0, 7) == 0);
         bus.m_rdata  = $urandom;
         step();
         check("gnt_excl", bus.i_gnt & bus.d_gnt, 0);
         check("err_excl", bus.i_err & bus.d_err, 0);
         check("rv_excl", obs_i_rv & obs_d_rv, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
